reg_access_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit register among N_REQ requesters.
- The register has synchronous reset, set and load.
- Each requester posts one of four ops (load, set, clear, read). The block grants one requester at a time and drives the register's reset/set/load/D controls for exactly one cycle.
- It returns a done pulse with the resulting register value.
- It sits between the control logic of several lab datapaths and the shared 4-bit register.

---
 rtl/reg_access_arbiter_pkg.sv | 27 ++
 rtl/reg_access_arbiter_rr_pick.sv | 35 +++
 rtl/reg_access_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_access_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_access_arbiter_pkg.sv
// Shared definitions for the register access arbiter.
//   op_t      : per-requester command encoding (load / set / clear / read)
//   state_t   : sequencer states IDLE -> ISSUE -> DONE -> IDLE
//   wrap_add  : (base + off) modulo n, for base, off < n
package reg_access_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Modulo add without a divider; both operands are already below n.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off >= n) ? (base + off - n) : (base + off);
  endfunction

endpackage

// File: rtl/reg_access_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   pointer    : index with highest priority this round
//   winner     : one-hot of the first set bit of req at or after pointer (wrapping)
//   winner_idx : binary index of that bit
//   any        : req has at least one bit set
module reg_access_arbiter_rr_pick
  import reg_access_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise the unassigned paths would infer latches.
    winner_idx = '0;
    // Scan from the farthest offset down so the closest match to the
    // pointer is the last (and therefore winning) assignment.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IDX_W'(wrap_add(32'(pointer), k, N_REQ))]) begin
        winner_idx = IDX_W'(wrap_add(32'(pointer), k, N_REQ));
      end
    end
    any    = |req;
    winner = any ? (N_REQ'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one external WIDTH-bit register
// among N_REQ requesters. One op is issued at a time as a single-cycle
// command on the register's reset/set/load/D pins, then acknowledged with
// a done pulse carrying the register value.
//   Clk, reset            : clock and synchronous active-high reset
//   req, op, wdata        : per-requester request level, op code, load data
//   gnt                   : one-hot grant during the ISSUE cycle
//   done, done_id, rdata  : completion pulse, requester index, register value
//   busy                  : high in ISSUE and DONE
//   reg_reset/set/load/D  : command to the shared register
//   reg_Q                 : register output
module reg_access_arbiter
  import reg_access_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic [IDX_W-1:0]       done_id,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy,
  output logic                   reg_reset,
  output logic                   reg_set,
  output logic                   reg_load,
  output logic [WIDTH-1:0]       reg_D,
  input  logic [WIDTH-1:0]       reg_Q
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] win_q;
  logic [N_REQ-1:0] win_oh_q;
  op_t              op_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  reg_access_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .pointer    (ptr_q),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge Clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      op_q     <= OP_LOAD;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // The request is captured here; later changes to req/op/wdata
          // cannot disturb the op in flight.
          if (pick_any) begin
            win_q    <= pick_idx;
            win_oh_q <= pick_oh;
            op_q     <= op_t'(op[2*int'(pick_idx) +: 2]);
            wdata_q  <= wdata[WIDTH*int'(pick_idx) +: WIDTH];
          end
        end
        ISSUE:   ptr_q   <= IDX_W'(wrap_add(32'(win_q), 1, N_REQ));
        DONE:    rdata_q <= reg_Q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    done      = 1'b0;
    done_id   = '0;
    rdata     = rdata_q;
    busy      = 1'b0;
    reg_reset = 1'b0;
    reg_set   = 1'b0;
    reg_load  = 1'b0;
    reg_D     = '0;

    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are forced low while reset is high so an ISSUE cut short by
    // reset sends nothing to the register besides its own reset.
    if (reset) begin
      rdata = '0;
    end else begin
      case (state_q)
        ISSUE: begin
          gnt  = win_oh_q;
          busy = 1'b1;
          case (op_q)
            OP_LOAD: begin
              reg_load = 1'b1;
              reg_D    = wdata_q;
            end
            OP_SET:  reg_set   = 1'b1;
            OP_CLR:  reg_reset = 1'b1;
            default: ;
          endcase
        end
        DONE: begin
          done    = 1'b1;
          done_id = win_q;
          rdata   = reg_Q;
          busy    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: the driver predicts each round's
// grant order and register values with a simple reference model and queues
// them; the monitor checks DUT outputs on every falling edge.
module tb_reg_access_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op = '0;
  logic [W*N-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic           done;
  logic [1:0]     done_id;
  logic [W-1:0]   rdata;
  logic           busy;
  logic           reg_reset, reg_set, reg_load;
  logic [W-1:0]   reg_D;
  logic [W-1:0]   reg_Q = '0;

  reg_access_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .req       (req),
    .op        (op),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .done_id   (done_id),
    .rdata     (rdata),
    .busy      (busy),
    .reg_reset (reg_reset),
    .reg_set   (reg_set),
    .reg_load  (reg_load),
    .reg_D     (reg_D),
    .reg_Q     (reg_Q)
  );

  always #5 Clk = ~Clk;

  // The shared external register, sharing the system reset.
  always @(posedge Clk) begin
    if (reset)          reg_Q <= '0;
    else if (reg_reset) reg_Q <= '0;
    else if (reg_set)   reg_Q <= '1;
    else if (reg_load)  reg_Q <= reg_D;
  end

  typedef struct { int id; logic [1:0] op; logic [W-1:0] d; } iss_t;
  typedef struct { int id; logic [W-1:0] q; } done_t;

  iss_t   iss_q[$];
  done_t  done_q[$];
  int     model_ptr = 0;
  logic [W-1:0] model_q = '0;
  logic [W-1:0] last_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each requester in mask is served once, winners picked
  // as the first pending index at or after the pointer.
  task automatic predict(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                         input logic [W*N-1:0] wd);
    logic [N-1:0] left;
    int    w;
    iss_t  ie;
    done_t de;
    left = mask;
    while (left != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && left[(model_ptr + k) % N]) w = (model_ptr + k) % N;
      left[w] = 1'b0;
      ie.id = w;
      ie.op = ops[2*w +: 2];
      ie.d  = wd[W*w +: W];
      case (ie.op)
        2'b00:   model_q = ie.d;
        2'b01:   model_q = '1;
        2'b10:   model_q = '0;
        default: ;
      endcase
      de.id = w;
      de.q  = model_q;
      iss_q.push_back(ie);
      done_q.push_back(de);
      model_ptr = (w + 1) % N;
    end
  endtask

  // hold=1: requesters keep req high after their grant until the whole set
  // is served; hold=0: each drops req and scrambles op/wdata on its grant.
  task automatic run_round(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                           input logic [W*N-1:0] wd, input bit hold);
    int served, cycles, n;
    n = $countones(mask);
    predict(mask, ops, wd);
    op = ops;
    wdata = wd;
    req = mask;
    served = 0;
    cycles = 0;
    while (served < n && cycles < 4*n + 8) begin
      @(negedge Clk);
      cycles++;
      if (gnt != '0) begin
        served++;
        if (!hold) begin
          for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
              req[i] = 1'b0;
              op[2*i +: 2] = op[2*i +: 2] ^ 2'b01;
              wdata[W*i +: W] = ~wdata[W*i +: W];
            end
          end
        end
        if (served == n) req = '0;
      end
    end
    check("round_grant_count", served, n);
    if (served < n) begin
      req = '0;
      iss_q.delete();
      done_q.delete();
    end
    repeat (2) @(negedge Clk);
  endtask

  // Monitor
  initial begin
    iss_t  ie;
    done_t de;
    forever begin
      @(negedge Clk);
      if (reset) begin
        check("reset_outputs", {gnt, done, done_id, busy, reg_reset, reg_set, reg_load, reg_D, rdata}, 0);
        last_rdata = '0;
      end else if (gnt != '0) begin
        if (iss_q.size() == 0) begin
          check("unexpected_gnt", gnt, 0);
        end else begin
          ie = iss_q.pop_front();
          check("gnt", gnt, 32'(1) << ie.id);
          check("issue_ctl", {reg_reset, reg_set, reg_load},
                {ie.op == 2'b10, ie.op == 2'b01, ie.op == 2'b00});
          check("issue_D", reg_D, (ie.op == 2'b00) ? ie.d : '0);
          check("issue_busy_done", {busy, done}, 2'b10);
          check("issue_rdata_hold", rdata, last_rdata);
        end
      end else if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          de = done_q.pop_front();
          check("done_id", done_id, de.id);
          check("rdata", rdata, de.q);
          check("done_quiet", {busy, reg_reset, reg_set, reg_load, reg_D}, {1'b1, 3'b000, W'(0)});
          last_rdata = de.q;
        end
      end else begin
        check("idle_outputs", {busy, reg_reset, reg_set, reg_load, reg_D}, 0);
        check("idle_rdata_hold", rdata, last_rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    iss_t ie;
    logic [N-1:0] m;

    reset = 1'b1;
    repeat (2) @(negedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    check("post_reset_outputs", {gnt, done, busy, reg_reset, reg_set, reg_load, reg_D, rdata}, 0);
    check("post_reset_reg_q", reg_Q, 0);

    // Single requester 2 loads A; op flips to set during ISSUE.
    run_round(4'b0100, 8'h00, 16'h0A00, 1'b0);
    // Grant to 3, then 1001 wraps to 0 before 3.
    run_round(4'b1000, 8'hC0, 16'h0000, 1'b0);
    run_round(4'b1001, 8'hC3, 16'h0000, 1'b0);
    // All four held: set, clear, load 5, read.
    run_round(4'b1111, 8'b11_00_10_01, 16'h0500, 1'b1);

    for (int r = 0; r < 40; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      run_round(m, (2*N)'($urandom), (W*N)'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset during ISSUE of a load 7 with the register previously all ones.
    run_round(4'b0001, 8'h01, 16'h0000, 1'b0);
    ie.id = 1; ie.op = 2'b00; ie.d = 4'h7;
    iss_q.push_back(ie);
    req = 4'b0010; op = 8'h00; wdata = 16'h0070;
    cyc = 0;
    while (gnt == '0 && cyc < 10) begin
      @(negedge Clk);
      cyc++;
    end
    check("abort_gnt_seen", gnt, 4'b0010);
    #1 reset = 1'b1;
    req = '0;
    @(negedge Clk);
    check("abort_outputs", {done, gnt, busy, rdata}, 0);
    check("abort_reg_q", reg_Q, 0);
    #1 reset = 1'b0;
    model_ptr = 0;
    model_q = '0;
    @(negedge Clk);

    // Pointer restarts at 0 after reset.
    run_round(4'b1111, (2*N)'($urandom), (W*N)'($urandom), 1'b0);
    for (int r = 0; r < 10; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      run_round(m, (2*N)'($urandom), (W*N)'($urandom), bit'($urandom_range(0, 1)));
    end

    check("issue_queue_drained", iss_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
